// File: rtl/memory_stage_if.sv
// Data memory bus between the memory stage and the data memory.
// The stage drives request/address/data; memory answers with ack/rdata.
interface memory_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// MEM pipeline stage: passes ALU ops through in one cycle, runs loads and
// stores against a handshaked data memory with a timeout and sticky error.
module memory_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [31:0]   ALU_Result_In,
    input  logic [31:0]   Store_Data,
    input  logic [7:0]    Dob_In,
    input  logic [3:0]    Rg_In,
    input  logic          sel_dat_In,
    input  logic          reg_we_In,
    input  logic          mem_read,
    input  logic          mem_write,
    memory_stage_if.master bus,
    output logic          stall,
    output logic [31:0]   Do,
    output logic [31:0]   ALU_Result,
    output logic [7:0]    Dob,
    output logic [3:0]    Rg,
    output logic          sel_dat,
    output logic          reg_we,
    output logic          valid_out,
    output logic          err
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    // Last counter value before the request is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic        is_store;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  dob_q;
    logic [3:0]  rg_q;
    logic        sel_q;
    logic        we_q;
    logic        mem_op;
    logic        take;
    logic        ack_done;
    logic        tmo;

    // Handshake decode and next-state / memory-bus outputs.
    always_comb begin
        state_nx      = state;
        mem_op        = mem_read | mem_write;
        take          = (state == IDLE) && valid_in;
        ack_done      = (state == ACCESS) && bus.mem_ack;
        tmo           = (state == ACCESS) && !bus.mem_ack &&
                        (cnt == TMO_LAST);
        stall         = (state == ACCESS);
        bus.mem_req   = (state == ACCESS);
        bus.mem_we    = (state == ACCESS) && is_store;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        unique case (state)
            IDLE:   if (valid_in && mem_op) state_nx = ACCESS;
            ACCESS: if (bus.mem_ack || tmo) state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Access-cycle counter: cleared on entry, counts unacknowledged cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (take && mem_op) begin
            cnt <= 8'd0;
        end else if (state == ACCESS && !bus.mem_ack) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Request latch and registered writeback fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store   <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            dob_q      <= 8'd0;
            rg_q       <= 4'd0;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            Do         <= 32'd0;
            ALU_Result <= 32'd0;
            Dob        <= 8'd0;
            Rg         <= 4'd0;
            sel_dat    <= 1'b0;
            reg_we     <= 1'b0;
            valid_out  <= 1'b0;
            err        <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (take && !mem_op) begin
                ALU_Result <= ALU_Result_In;
                Dob        <= Dob_In;
                Rg         <= Rg_In;
                sel_dat    <= sel_dat_In;
                reg_we     <= reg_we_In;
                Do         <= 32'd0;
                valid_out  <= 1'b1;
            end else if (take) begin
                is_store <= mem_write;
                addr_q   <= ALU_Result_In;
                wdata_q  <= Store_Data;
                dob_q    <= Dob_In;
                rg_q     <= Rg_In;
                sel_q    <= sel_dat_In;
                we_q     <= reg_we_In;
            end
            if (ack_done || tmo) begin
                ALU_Result <= addr_q;
                Dob        <= dob_q;
                Rg         <= rg_q;
                sel_dat    <= sel_q;
                valid_out  <= 1'b1;
                if (ack_done && !is_store) begin
                    Do     <= bus.mem_rdata;
                    reg_we <= we_q;
                end else begin
                    Do     <= 32'd0;
                    reg_we <= 1'b0;
                end
                if (tmo) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a transaction-level reference model
// and a per-cycle comparator, plus literal checks on key results.
module tb_memory_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] ALU_Result_In = '0;
    logic [31:0] Store_Data = '0;
    logic [7:0]  Dob_In = '0;
    logic [3:0]  Rg_In = '0;
    logic        sel_dat_In = 1'b0;
    logic        reg_we_In = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        stall;
    logic [31:0] Do;
    logic [31:0] ALU_Result;
    logic [7:0]  Dob;
    logic [3:0]  Rg;
    logic        sel_dat;
    logic        reg_we;
    logic        valid_out;
    logic        err;

    memory_stage_if bus();

    memory_stage #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .ALU_Result_In (ALU_Result_In),
        .Store_Data    (Store_Data),
        .Dob_In        (Dob_In),
        .Rg_In         (Rg_In),
        .sel_dat_In    (sel_dat_In),
        .reg_we_In     (reg_we_In),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .bus           (bus),
        .stall         (stall),
        .Do            (Do),
        .ALU_Result    (ALU_Result),
        .Dob           (Dob),
        .Rg            (Rg),
        .sel_dat       (sel_dat),
        .reg_we        (reg_we),
        .valid_out     (valid_out),
        .err           (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding memory op, tracked as a record.
    bit          m_busy;
    bit          m_store;
    logic [31:0] m_addr, m_wdata;
    logic [7:0]  m_dob;
    logic [3:0]  m_rg;
    bit          m_sel, m_we;
    int          m_waited;
    bit          m_valid, m_err;
    logic [31:0] m_do, m_alu;
    logic [7:0]  m_dobo;
    logic [3:0]  m_rgo;
    bit          m_selo, m_weo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_store <= 0; m_addr <= 0; m_wdata <= 0;
            m_waited <= 0; m_valid <= 0; m_err <= 0;
            m_do <= 0; m_alu <= 0; m_dobo <= 0; m_rgo <= 0;
            m_selo <= 0; m_weo <= 0;
        end else begin
            m_valid <= 0;
            if (!m_busy) begin
                if (valid_in && (mem_read || mem_write)) begin
                    m_busy <= 1; m_store <= mem_write;
                    m_addr <= ALU_Result_In; m_wdata <= Store_Data;
                    m_dob <= Dob_In; m_rg <= Rg_In;
                    m_sel <= sel_dat_In; m_we <= reg_we_In;
                    m_waited <= 0;
                end else if (valid_in) begin
                    m_valid <= 1; m_do <= 0; m_alu <= ALU_Result_In;
                    m_dobo <= Dob_In; m_rgo <= Rg_In;
                    m_selo <= sel_dat_In; m_weo <= reg_we_In;
                end
            end else if (bus.mem_ack) begin
                m_busy <= 0; m_valid <= 1; m_alu <= m_addr;
                m_do <= m_store ? 32'd0 : bus.mem_rdata;
                m_weo <= m_store ? 1'b0 : m_we;
                m_dobo <= m_dob; m_rgo <= m_rg; m_selo <= m_sel;
            end else if (m_waited + 1 >= TMO) begin
                m_busy <= 0; m_valid <= 1; m_alu <= m_addr;
                m_do <= 0; m_weo <= 0; m_err <= 1;
                m_dobo <= m_dob; m_rgo <= m_rg; m_selo <= m_sel;
            end else begin
                m_waited <= m_waited + 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_stall", stall, 0);
            chk("rst_req", bus.mem_req, 0);
            chk("rst_we", bus.mem_we, 0);
            chk("rst_addr", bus.mem_addr, 0);
            chk("rst_wdata", bus.mem_wdata, 0);
            chk("rst_valid", valid_out, 0);
            chk("rst_err", err, 0);
            chk("rst_do", Do, 0);
            chk("rst_alu", ALU_Result, 0);
            chk("rst_fields", {Dob, Rg, sel_dat, reg_we}, 0);
        end else begin
            chk("stall", stall, m_busy);
            chk("mem_req", bus.mem_req, m_busy);
            chk("mem_we", bus.mem_we, m_busy && m_store);
            chk("valid_out", valid_out, m_valid);
            chk("err", err, m_err);
            if (m_busy) begin
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (m_valid) begin
                chk("Do", Do, m_do);
                chk("ALU_Result", ALU_Result, m_alu);
                chk("Dob", Dob, m_dobo);
                chk("Rg", Rg, m_rgo);
                chk("sel_dat", sel_dat, m_selo);
                chk("reg_we", reg_we, m_weo);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_in();
        valid_in = 0; mem_read = 0; mem_write = 0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] rg, input logic [7:0] db,
                         input bit sel, input bit we,
                         input bit rd, input bit wr);
        valid_in = 1; ALU_Result_In = a; Store_Data = d;
        Rg_In = rg; Dob_In = db; sel_dat_In = sel; reg_we_In = we;
        mem_read = rd; mem_write = wr;
    endtask

    initial begin
        clear_in();
        repeat (3) step();
        chk("lit_rst_valid", valid_out, 0);
        rst = 0;
        step();

        // ALU op: one-cycle pass-through.
        issue(32'h1245, 32'h0, 4'd4, 8'd3, 0, 1, 0, 0);
        step();
        clear_in();
        chk("lit_alu_valid", valid_out, 1);
        chk("lit_alu_res", ALU_Result, 32'h1245);
        chk("lit_alu_rg", Rg, 4);
        chk("lit_alu_dob", Dob, 3);
        chk("lit_alu_do", Do, 0);
        chk("lit_alu_stall", stall, 0);
        step();
        chk("lit_alu_pulse", valid_out, 0);

        // Load, ack in third ACCESS cycle.
        issue(32'h10, 32'h0, 4'd7, 8'd9, 1, 1, 1, 0);
        step();
        clear_in();
        chk("lit_ld_stall1", stall, 1);
        chk("lit_ld_addr", bus.mem_addr, 32'h10);
        step();
        chk("lit_ld_stall2", stall, 1);
        step();
        chk("lit_ld_stall3", stall, 1);
        bus.mem_ack = 1; bus.mem_rdata = 32'hEA4;
        step();
        clear_in();
        chk("lit_ld_valid", valid_out, 1);
        chk("lit_ld_do", Do, 32'hEA4);
        chk("lit_ld_sel", sel_dat, 1);
        chk("lit_ld_stall_end", stall, 0);

        // Store (read also set: store wins), immediate ack.
        issue(32'h20, 32'hBBB, 4'd5, 8'd1, 0, 1, 1, 1);
        step();
        clear_in();
        chk("lit_st_we", bus.mem_we, 1);
        chk("lit_st_wdata", bus.mem_wdata, 32'hBBB);
        bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD;
        step();
        clear_in();
        chk("lit_st_valid", valid_out, 1);
        chk("lit_st_regwe", reg_we, 0);
        chk("lit_st_do", Do, 0);
        chk("lit_st_we_off", bus.mem_we, 0);

        // Ack while idle alongside an ALU op.
        issue(32'h77, 32'h0, 4'd2, 8'd8, 0, 1, 0, 0);
        bus.mem_ack = 1; bus.mem_rdata = 32'h55;
        step();
        clear_in();
        chk("lit_idleack_do", Do, 0);
        chk("lit_idleack_alu", ALU_Result, 32'h77);
        chk("lit_idleack_stall", stall, 0);
        step();

        // Ack coinciding with the last allowed cycle: ack wins.
        issue(32'h40, 32'h0, 4'd3, 8'd4, 0, 1, 1, 0);
        repeat (3) step();
        clear_in();
        step();
        chk("lit_edge_req4", bus.mem_req, 1);
        bus.mem_ack = 1; bus.mem_rdata = 32'h1234;
        step();
        clear_in();
        chk("lit_edge_do", Do, 32'h1234);
        chk("lit_edge_err", err, 0);

        // Timeout: no ack.
        issue(32'h30, 32'h0, 4'd6, 8'd2, 0, 1, 1, 0);
        step();
        clear_in();
        for (int i = 0; i < TMO; i++) begin
            chk("lit_tmo_req", bus.mem_req, 1);
            step();
        end
        chk("lit_tmo_valid", valid_out, 1);
        chk("lit_tmo_do", Do, 0);
        chk("lit_tmo_regwe", reg_we, 0);
        chk("lit_tmo_err", err, 1);
        issue(32'h99, 32'h0, 4'd1, 8'd1, 0, 1, 0, 0);
        step();
        clear_in();
        chk("lit_err_sticky", err, 1);

        // Reset in the second ACCESS cycle.
        issue(32'h50, 32'h0, 4'd8, 8'd5, 0, 1, 1, 0);
        step();
        clear_in();
        step();
        chk("lit_rst2_req_pre", bus.mem_req, 1);
        #2;
        rst = 1;
        #1;
        chk("lit_rst2_req", bus.mem_req, 0);
        chk("lit_rst2_stall", stall, 0);
        chk("lit_rst2_err", err, 0);
        chk("lit_rst2_valid", valid_out, 0);
        step();
        rst = 0;
        step();
        chk("lit_rst2_novalid", valid_out, 0);
        issue(32'hABC, 32'h0, 4'd9, 8'd6, 1, 1, 0, 0);
        step();
        clear_in();
        chk("lit_post_valid", valid_out, 1);
        chk("lit_post_alu", ALU_Result, 32'hABC);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: TIMEOUT, default 255, max ACCESS cycles before the request is abandoned (1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 valid_in  in  1  EX/MEM slot holds an instruction.
REQ-005 ALU_Result_In  in  32  ALU result; also the memory address.
REQ-006 Store_Data  in  32  store write data.
REQ-007 Dob_In  in  8  pixel byte passed to writeback.
REQ-008 Rg_In  in  4  destination register.
REQ-009 sel_dat_In  in  1  writeback select (1 = memory data, 0 = ALU result).
REQ-010 reg_we_In  in  1  instruction writes the register file.
REQ-011 mem_read, mem_write  in  1 each  load / store request.
REQ-012 mem_ack  in  1  data memory completion strobe; mem_rdata valid when high.
REQ-013 mem_rdata  in  32  data memory read data.
REQ-014 mem_req, mem_we  out  1 each  memory request / write enable.
REQ-015 mem_addr, mem_wdata  out  32 each  latched address / store data.
REQ-016 stall  out  1  upstream SHALL hold EX/MEM contents while high.
REQ-017 Do, ALU_Result  out  32 each  registered writeback operands.
REQ-018 Dob  out  8; Rg  out  4; sel_dat  out  1; reg_we  out  1  registered writeback fields.
REQ-019 valid_out  out  1  one-cycle pulse: writeback fields are valid.
REQ-020 err  out  1  sticky memory timeout flag.

Function
REQ-021 FSM states: IDLE, ACCESS.
REQ-022 stall SHALL equal (state == ACCESS), combinationally from state only.
REQ-023 In IDLE, valid_in=1 with mem_read=mem_write=0: the block SHALL register all fields at that edge, with Do=0 and valid_out=1; latency is 1 cycle and the FSM stays in IDLE.
REQ-024 In IDLE, valid_in=1 with mem_read|mem_write: the block SHALL latch address, data, fields and op at that edge and move to ACCESS; valid_out=0.
REQ-025 mem_write=1 SHALL take priority over mem_read when both are set; the access is treated as a store.
REQ-026 In ACCESS: mem_req=1; mem_we=1 for a store; mem_addr and mem_wdata hold latched values stable; valid_in is ignored.
REQ-027 Outside ACCESS: mem_req=0 and mem_we=0.
REQ-028 mem_ack=1 in ACCESS at an edge SHALL register the outputs, pulse valid_out, and return to IDLE.
REQ-029 On ack for a load, Do SHALL be mem_rdata.
REQ-030 On ack for a store, Do SHALL be 0 and reg_we SHALL be 0.
REQ-031 Minimum memory-op latency is 2 cycles (ack in the first ACCESS cycle).
REQ-032 A cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-033 When the counter reaches TIMEOUT without ack, the FSM SHALL return to IDLE with valid_out=1, Do=0, reg_we=0, and err=1; err stays set until reset.
REQ-034 If mem_ack and timeout coincide, ack SHALL win and err is not set.
REQ-035 mem_ack while in IDLE SHALL be ignored.
REQ-036 valid_out SHALL be 0 in every cycle other than those stated above.

Reset
REQ-037 While rst=1, regardless of clk: state=IDLE, counter=0, and all outputs 0 (Do, ALU_Result, Dob, Rg, sel_dat, reg_we, valid_out, err, mem_req, mem_we, mem_addr, mem_wdata, stall).
REQ-038 Reset during ACCESS SHALL abandon the request: mem_req drops immediately and no valid_out is produced for it.

Verification
REQ-039 ALU op: ALU_Result_In=32'h1245, Rg_In=4, Dob_In=3, reg_we_In=1 -> next cycle valid_out=1, ALU_Result=32'h1245, Rg=4, Dob=3, Do=0, stall never high.
REQ-040 Load at 32'h10, mem_ack 3 cycles after ACCESS entry with mem_rdata=32'hEA4 -> stall high 3 cycles, mem_req high with mem_addr=32'h10, then valid_out=1, Do=32'hEA4, sel_dat follows sel_dat_In.
REQ-041 Store 32'hBBB to 32'h20 with reg_we_In=1, immediate ack -> mem_we=1, mem_wdata=32'hBBB for 1 cycle, then valid_out=1, reg_we=0, Do=0.
REQ-042 TIMEOUT=4, load with no ack -> mem_req high 4 cycles, then valid_out=1, Do=0, err=1 and still 1 after following ops; err clears only on rst.
REQ-043 Reset pulse in the second ACCESS cycle -> mem_req, stall, and all outputs 0 immediately; no valid_out; next ALU op processes normally.
REQ-044 mem_ack asserted while IDLE alongside an ALU op -> the ALU op completes normally and no spurious load data appears on Do.
